// File: rtl/equiv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// equiv_seq_ctrl
//
// Self-checking sequencer for an equivalence datapath. It drives pseudo-random
// reset/enable/data stimulus into a pair of implementations (a reference
// "good" one and a "bad" one under check), compares their responses each
// cycle and latches pass/fail plus details of the first mismatch.
//
// Sequence: IDLE -> RESET (RST_CYCLES) -> RUN (N cycles) -> DRAIN (1) -> DONE
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start_i           start a run (only honoured in IDLE or DONE)
//   abort_i           return to IDLE immediately (beats start_i)
//   num_cycles_i      RUN length N, sampled when a run starts
//   dut_rst_o/en_o/data_o  registered stimulus to both implementations
//   good_i, bad_i     responses of the reference / checked implementation
//   busy_o, done_o    run in progress / run finished
//   pass_o            valid while done_o; 1 = no mismatch seen
//   mismatch_count_o  saturating mismatch count
//   fail_cycle_o      RUN index of the stimulus that caused the first mismatch
//   fail_good_o/bad_o responses captured at the first mismatch
//
// Optional feature macro: EQUIV_STOP_ON_FAIL_EN
//   defined   - the first mismatch ends the run (straight to DONE)
//   undefined - the run always completes N cycles and counts every mismatch
// -----------------------------------------------------------------------------
module equiv_seq_ctrl #(
   parameter int          WIDTH      = 8,
   parameter int          OUT_WIDTH  = 8,
   parameter int          RST_CYCLES = 2,
   parameter int          RST_SHIFT  = 3,
   parameter int          EN_SHIFT   = 3,
   parameter logic [31:0] SEED       = 32'hACE1_2024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [31:0]          num_cycles_i,
   output logic                 dut_rst_o,
   output logic                 dut_en_o,
   output logic [WIDTH-1:0]     dut_data_o,
   input  logic [OUT_WIDTH-1:0] good_i,
   input  logic [OUT_WIDTH-1:0] bad_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [15:0]          mismatch_count_o,
   output logic [31:0]          fail_cycle_o,
   output logic [OUT_WIDTH-1:0] fail_good_o,
   output logic [OUT_WIDTH-1:0] fail_bad_o
);

   // A zero seed would lock the LFSR at zero forever.
   localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
   // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1.
   localparam logic [31:0] TAPS     = 32'h8020_0003;
   localparam int          CNT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_reg, state_next;
   logic [31:0]           lfsr_reg, lfsr_next;
   logic [31:0]           k_reg, k_next;
   logic [31:0]           n_reg, n_next;
   logic [CNT_W-1:0]      rst_cnt_reg, rst_cnt_next;
   logic                  dut_rst_reg, dut_rst_next;
   logic                  dut_en_reg, dut_en_next;
   logic [WIDTH-1:0]      dut_data_reg, dut_data_next;
   logic [15:0]           mcount_reg, mcount_next;
   logic [31:0]           fail_cycle_reg, fail_cycle_next;
   logic [OUT_WIDTH-1:0]  fail_good_reg, fail_good_next;
   logic [OUT_WIDTH-1:0]  fail_bad_reg, fail_bad_next;
   logic                  pass_reg, pass_next;

   // Stimulus derived from the current LFSR value; it is registered onto the
   // dut_* outputs as a RUN cycle begins, then the LFSR steps.
   logic                  stim_rst;
   logic                  stim_en;
   logic [WIDTH-1:0]      stim_data;

   // Compare bookkeeping
   logic                  compare_en;
   logic                  mismatch;
   logic                  first_fail;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      lfsr_step = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
   endfunction

   always_comb begin
      stim_rst  = (lfsr_reg[RST_SHIFT-1:0] == '0);
      stim_en   = !stim_rst && (lfsr_reg[RST_SHIFT+EN_SHIFT-1:RST_SHIFT] == '0);
      stim_data = lfsr_reg[31:32-WIDTH];
   end

   // Each check looks at the response to the previous cycle's stimulus, so
   // RUN cycle 0 has nothing to compare yet and DRAIN checks the last one.
   always_comb begin
      compare_en = ((state_reg == S_RUN) && (k_reg != 32'd0)) || (state_reg == S_DRAIN);
      mismatch   = compare_en && (good_i != bad_i);
      // The count never returns to zero within a run, so zero marks "no
      // mismatch captured yet".
      first_fail = mismatch && (mcount_reg == 16'd0);
   end

   // Next-state / next-output logic
   always_comb begin
      state_next      = state_reg;
      lfsr_next       = lfsr_reg;
      k_next          = k_reg;
      n_next          = n_reg;
      rst_cnt_next    = rst_cnt_reg;
      dut_rst_next    = dut_rst_reg;
      dut_en_next     = dut_en_reg;
      dut_data_next   = dut_data_reg;
      mcount_next     = mcount_reg;
      fail_cycle_next = fail_cycle_reg;
      fail_good_next  = fail_good_reg;
      fail_bad_next   = fail_bad_reg;
      pass_next       = pass_reg;

      if (abort_i) begin
         // Abort wins over start and over any compare in this cycle; the
         // result registers keep whatever they had accumulated.
         state_next   = S_IDLE;
         dut_rst_next = 1'b1;
         dut_en_next  = 1'b0;
      end else begin
         if (mismatch) begin
            if (mcount_reg != 16'hFFFF) begin
               mcount_next = mcount_reg + 16'd1;
            end
         end
         if (first_fail) begin
            fail_cycle_next = (state_reg == S_DRAIN) ? (n_reg - 32'd1) : (k_reg - 32'd1);
            fail_good_next  = good_i;
            fail_bad_next   = bad_i;
         end

         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_next      = S_RESET;
                  n_next          = num_cycles_i;
                  lfsr_next       = SEED_EFF;
                  k_next          = 32'd0;
                  rst_cnt_next    = '0;
                  mcount_next     = 16'd0;
                  fail_cycle_next = 32'd0;
                  fail_good_next  = '0;
                  fail_bad_next   = '0;
                  pass_next       = 1'b0;
                  dut_rst_next    = 1'b1;
                  dut_en_next     = 1'b0;
               end
            end

            S_RESET: begin
               rst_cnt_next = rst_cnt_reg + 1'b1;
               if (rst_cnt_reg == RST_LAST) begin
                  if (n_reg == 32'd0) begin
                     // Empty run: no stimulus, LFSR untouched.
                     state_next   = S_DRAIN;
                     dut_rst_next = 1'b0;
                     dut_en_next  = 1'b0;
                  end else begin
                     state_next    = S_RUN;
                     k_next        = 32'd0;
                     dut_rst_next  = stim_rst;
                     dut_en_next   = stim_en;
                     dut_data_next = stim_data;
                     lfsr_next     = lfsr_step(lfsr_reg);
                  end
               end
            end

            S_RUN: begin
               if (k_reg == n_reg - 32'd1) begin
                  state_next   = S_DRAIN;
                  dut_rst_next = 1'b0;
                  dut_en_next  = 1'b0;
               end else begin
                  k_next        = k_reg + 32'd1;
                  dut_rst_next  = stim_rst;
                  dut_en_next   = stim_en;
                  dut_data_next = stim_data;
                  lfsr_next     = lfsr_step(lfsr_reg);
               end
            end

            S_DRAIN: begin
               state_next = S_DONE;
               pass_next  = (mcount_next == 16'd0);
            end

            default: begin
               state_next   = S_IDLE;
               dut_rst_next = 1'b1;
               dut_en_next  = 1'b0;
            end
         endcase

`ifdef EQUIV_STOP_ON_FAIL_EN
         // First mismatch ends the run: quiesce the stimulus and finish.
         if (first_fail) begin
            state_next    = S_DONE;
            dut_rst_next  = 1'b0;
            dut_en_next   = 1'b0;
            dut_data_next = dut_data_reg;
            lfsr_next     = lfsr_reg;
            k_next        = k_reg;
            pass_next     = 1'b0;
         end
`endif
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         lfsr_reg       <= SEED_EFF;
         k_reg          <= 32'd0;
         n_reg          <= 32'd0;
         rst_cnt_reg    <= '0;
         dut_rst_reg    <= 1'b1;
         dut_en_reg     <= 1'b0;
         dut_data_reg   <= '0;
         mcount_reg     <= 16'd0;
         fail_cycle_reg <= 32'd0;
         fail_good_reg  <= '0;
         fail_bad_reg   <= '0;
         pass_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         lfsr_reg       <= lfsr_next;
         k_reg          <= k_next;
         n_reg          <= n_next;
         rst_cnt_reg    <= rst_cnt_next;
         dut_rst_reg    <= dut_rst_next;
         dut_en_reg     <= dut_en_next;
         dut_data_reg   <= dut_data_next;
         mcount_reg     <= mcount_next;
         fail_cycle_reg <= fail_cycle_next;
         fail_good_reg  <= fail_good_next;
         fail_bad_reg   <= fail_bad_next;
         pass_reg       <= pass_next;
      end
   end

   assign dut_rst_o        = dut_rst_reg;
   assign dut_en_o         = dut_en_reg;
   assign dut_data_o       = dut_data_reg;
   assign busy_o           = (state_reg == S_RESET) || (state_reg == S_RUN) ||
                             (state_reg == S_DRAIN);
   assign done_o           = (state_reg == S_DONE);
   assign pass_o           = pass_reg;
   assign mismatch_count_o = mcount_reg;
   assign fail_cycle_o     = fail_cycle_reg;
   assign fail_good_o      = fail_good_reg;
   assign fail_bad_o       = fail_bad_reg;

endmodule

// File: doc/equiv_seq_ctrl.md
Name: equiv_seq_ctrl

Overview:
- Self-checking sequencer for the equivalence datapath: drives pseudo-random rst/en/data stimulus into paired good/bad implementations and compares their outputs every cycle.
- Runs a programmed number of cycles and latches pass/fail plus first-mismatch details.
- Synthesizable, so equivalence runs can go on FPGA or in formal harnesses as well as simulation.

Parameters:
WIDTH, 8, width of dut_data_o
OUT_WIDTH, 8, width of good_i/bad_i
RST_CYCLES, 2, cycles dut_rst_o is held high in the RESET state (>=1)
RST_SHIFT, 3, dut_rst_o pulses when lfsr[RST_SHIFT-1:0]==0, probability 2^-RST_SHIFT
EN_SHIFT, 3, dut_en_o asserted when lfsr[RST_SHIFT+EN_SHIFT-1:RST_SHIFT]==0
SEED, 32'hACE1_2024, LFSR seed; a value of 0 is replaced by 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  start a run; ignored unless state is IDLE or DONE
abort_i  in  1  terminate a run and return to IDLE
num_cycles_i  in  32  RUN length, sampled on start
dut_rst_o  out  1  reset to both DUTs
dut_en_o  out  1  enable to both DUTs
dut_data_o  out  WIDTH  data to both DUTs
good_i  in  OUT_WIDTH  reference DUT output
bad_i  in  OUT_WIDTH  DUT-under-check output
busy_o  out  1  high in RESET, RUN, DRAIN
done_o  out  1  high in DONE
pass_o  out  1  valid while done_o; 1 means no mismatch
mismatch_count_o  out  16  saturating mismatch count
fail_cycle_o  out  32  RUN cycle index of first mismatch
fail_good_o  out  OUT_WIDTH  good_i captured at first mismatch
fail_bad_o  out  OUT_WIDTH  bad_i captured at first mismatch

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - State IDLE; lfsr=SEED (0 replaced by 1).
  - dut_rst_o=1, dut_en_o=0, dut_data_o=0.
  - busy_o=0, done_o=0, pass_o=0.
  - Counters, fail_cycle_o, fail_good_o and fail_bad_o all 0.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1; advances once per RUN cycle only.
- Stimulus: dut_data_o=lfsr[31:32-WIDTH] (WIDTH<=32).
- States:
  - IDLE: dut_rst_o=1, dut_en_o=0. On start_i:
    - latch num_cycles_i;
    - clear mismatch_count_o, fail_* and pass_o;
    - reload lfsr=SEED;
    - go to RESET.
  - RESET: dut_rst_o=1, dut_en_o=0, held for exactly RST_CYCLES cycles.
    - Then go to RUN, or to DRAIN if the latched count is 0.
  - RUN: outputs registered from the current lfsr. Cycle index k runs from 0 to N-1.
    - dut_rst_o=(lfsr low bits==0).
    - dut_en_o per EN_SHIFT rule; forced 0 when dut_rst_o=1.
    - After N cycles go to DRAIN.
  - DRAIN: one cycle; dut_rst_o=0, dut_en_o=0, data held. Then go to DONE.
  - DONE: done_o=1; outputs hold until start_i (restart) or abort_i/rst.
- Compare:
  - Enabled in RUN cycles k>=1 and in DRAIN. Each check compares the DUT response to stimulus from the previous cycle, using `good_i != bad_i`.
  - On mismatch: mismatch_count_o increments, saturating at 16'hFFFF.
  - First mismatch only also captures:
    - fail_cycle_o = k-1, or N-1 in DRAIN;
    - fail_good_o and fail_bad_o = the compared values.
- Completion: pass_o=(mismatch_count_o==0), valid from the cycle done_o rises.
- Simultaneous events:
  - rst beats everything.
  - abort_i beats start_i; abort_i in any state goes to IDLE with done_o=0, and counters retain their values.
  - start_i while busy is ignored.
  - start_i in DONE clears results and restarts the same cycle.

Optional Feature:
EQUIV_STOP_ON_FAIL_EN
- Defined: the first mismatch forces the next state to DONE (skipping the rest of RUN and DRAIN); mismatch_count_o=1, pass_o=0.
- Undefined: the run always completes N cycles and counts every mismatch.

Test Plan:
1. good_i tied to bad_i, num_cycles_i=1000, start_i pulse -> busy_o for 2+1000+1 cycles, then done_o=1, pass_o=1, mismatch_count_o=0.
2. bad_i=good_i^8'h01 from RUN cycle 10 onward, N=100 -> pass_o=0, fail_cycle_o=10, fail_bad_o=fail_good_o^1, mismatch_count_o=90 (macro off) or 1 with done_o asserting in that same cycle (macro on).
3. num_cycles_i=0 -> RESET 2 cycles, DRAIN, DONE, pass_o=1, lfsr unchanged.
4. abort_i during RUN cycle 5, with start_i also high -> IDLE next cycle, done_o=0, dut_rst_o=1, start_i ignored.
5. Same SEED run twice back-to-back via start_i in DONE -> identical dut_* sequences; dut_en_o never 1 while dut_rst_o=1.
6. rst asserted mid-RUN -> next cycle all outputs at reset values, state IDLE.
